// File: rtl/csr_update_serializer.sv
// rtl/csr_update_serializer.sv - change-detecting CSR/priv update serializer for the difftest channel
// Shadows every source, queues the lowest-index dirty source each cycle, emits one update per handshake.
module csr_update_serializer #(
  parameter int NUM_CSR    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 12,
  parameter int DATA_W     = 64
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_CSR*(ID_W+DATA_W)-1:0]    csr_bus,
  input  logic [1:0]                          priv,
  input  logic                                resync,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_is_priv,
  output logic [ID_W-1:0]                     out_id,
  output logic [DATA_W-1:0]                   out_val,
  output logic [$clog2(FIFO_DEPTH):0]         pending
);

  localparam int ENTRY_W = ID_W + DATA_W;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int SRC_N   = NUM_CSR + 1;

  logic [ENTRY_W-1:0] entry  [NUM_CSR];
  logic [ENTRY_W-1:0] shadow [NUM_CSR];
  logic [1:0]         shadow_priv;
  logic [SRC_N-1:0]   shadow_ok;
  logic [SRC_N-1:0]   dirty;
  logic [SRC_N-1:0]   grant;
  logic [ENTRY_W-1:0] sel_entry;
  logic [ENTRY_W:0]   enq_data;
  logic [ENTRY_W:0]   mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               full;
  logic               empty;
  logic               enq;
  logic               deq;

  genvar g;
  generate
    for (g = 0; g < NUM_CSR; g++) begin : g_entry
      assign entry[g] = csr_bus[g*ENTRY_W +: ENTRY_W];
    end
  endgenerate

  always_comb begin
    dirty = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      dirty[i] = !shadow_ok[i] || (entry[i] != shadow[i]);
    end
    dirty[NUM_CSR] = !shadow_ok[NUM_CSR] || (priv != shadow_priv);
  end

  // Isolate the lowest set bit: priv sits at the top index so it always loses.
  assign grant = dirty & (~dirty + SRC_N'(1));

  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < NUM_CSR; i++) begin
      sel_entry = sel_entry | (entry[i] & {ENTRY_W{grant[i]}});
    end
  end

  assign enq_data = grant[NUM_CSR] ? {1'b1, {(ENTRY_W-2){1'b0}}, priv}
                                   : {1'b0, sel_entry};

  // Full is judged on registered pointers only, so a same-cycle pop never makes room.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign enq   = (|dirty) && !full;
  assign deq   = !empty && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CSR; i++) shadow[i] <= '0;
      shadow_priv <= '0;
      shadow_ok   <= '0;
    end else begin
      if (enq) begin
        for (int i = 0; i < NUM_CSR; i++) begin
          if (grant[i]) begin
            shadow[i]    <= entry[i];
            shadow_ok[i] <= 1'b1;
          end
        end
        if (grant[NUM_CSR]) begin
          shadow_priv        <= priv;
          shadow_ok[NUM_CSR] <= 1'b1;
        end
      end
      if (resync) shadow_ok <= '0;
    end
  end

  // Head is masked while empty so stale storage never shows on the outputs.
  assign out_valid = !empty;
  assign {out_is_priv, out_id, out_val} = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign pending   = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_csr_update_serializer.sv
// tb/tb_csr_update_serializer.sv - directed self-checking bench for csr_update_serializer
module tb_csr_update_serializer;

  logic          clock;
  logic          reset;
  logic [607:0]  csr_bus;
  logic [1:0]    priv;
  logic          resync;
  logic          out_valid;
  logic          out_ready;
  logic          out_is_priv;
  logic [11:0]   out_id;
  logic [63:0]   out_val;
  logic [4:0]    pending;

  logic [11:0]   ids  [8];
  logic [63:0]   vals [8];

  int            n_checks;
  int            n_fail;
  int            seen_cnt [8];
  logic [63:0]   last_val [8];
  int            priv_cnt;
  int            n_drained;

  csr_update_serializer dut (
    .clock       (clock),
    .reset       (reset),
    .csr_bus     (csr_bus),
    .priv        (priv),
    .resync      (resync),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_is_priv (out_is_priv),
    .out_id      (out_id),
    .out_val     (out_val),
    .pending     (pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    csr_bus = '0;
    for (int k = 0; k < 8; k++) csr_bus[k*76 +: 76] = {ids[k], vals[k]};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic expect_update(input string tag, input logic ip, input logic [11:0] id,
                               input logic [63:0] val);
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      tick();
      t++;
    end
    check({tag, " valid"}, out_valid, 1);
    if (out_valid) begin
      check({tag, " is_priv"}, out_is_priv, ip);
      check({tag, " id"}, out_id, id);
      check({tag, " val"}, out_val, val);
      tick();
    end
  endtask

  task automatic drain(input int cycles);
    for (int k = 0; k < 8; k++) begin
      seen_cnt[k] = 0;
      last_val[k] = '0;
    end
    priv_cnt  = 0;
    n_drained = 0;
    out_ready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (out_valid) begin
        n_drained++;
        if (out_is_priv) priv_cnt++;
        else begin
          for (int k = 0; k < 8; k++) begin
            if (out_id == ids[k]) begin
              seen_cnt[k]++;
              last_val[k] = out_val;
            end
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    resync    = 1'b0;
    out_ready = 1'b1;
    priv      = 2'd1;
    for (int k = 0; k < 8; k++) begin
      ids[k]  = 12'h300 + 12'(k);
      vals[k] = (k == 2) ? 64'h0 : 64'h1000 + 64'(k);
    end
    repeat (3) tick();

    check("rst out_valid", out_valid, 0);
    check("rst pending", pending, 0);
    check("rst out_id", out_id, 0);
    check("rst out_val", out_val, 0);
    check("rst out_is_priv", out_is_priv, 0);

    // T1: all sources dirty after reset
    reset = 1'b0;
    for (int k = 0; k < 8; k++) expect_update($sformatf("t1 e%0d", k), 1'b0, ids[k], vals[k]);
    expect_update("t1 priv", 1'b1, 12'h0, 64'd1);
    for (int c = 0; c < 4; c++) begin
      check("t1 idle", out_valid, 0);
      tick();
    end

    // T2: single change, one-cycle latency
    vals[2] = 64'h1234;
    tick();
    check("t2 valid", out_valid, 1);
    check("t2 id", out_id, ids[2]);
    check("t2 val", out_val, 64'h1234);
    tick();
    for (int c = 0; c < 3; c++) begin
      check("t2 single", out_valid, 0);
      tick();
    end

    // T3: saturate the queue with ready low, then drain
    out_ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      vals[c % 8] = 64'h5000 + 64'(c);
      tick();
      check("t3 pending_le16", pending <= 5'd16, 1);
    end
    check("t3 pending_full", pending, 16);
    drain(60);
    for (int k = 0; k < 8; k++) check($sformatf("t3 final e%0d", k), last_val[k], 64'h5010 + 64'(k));
    check("t3 no_priv", priv_cnt, 0);
    check("t3 pending_empty", pending, 0);

    // T4: same-cycle changes come out lowest index first
    vals[1] = 64'h5151;
    vals[5] = 64'h5555;
    priv    = 2'd3;
    tick();
    check("t4 v1", out_valid, 1);
    check("t4 id1", out_id, ids[1]);
    check("t4 val1", out_val, 64'h5151);
    tick();
    check("t4 v5", out_valid, 1);
    check("t4 id5", out_id, ids[5]);
    check("t4 val5", out_val, 64'h5555);
    tick();
    check("t4 vp", out_valid, 1);
    check("t4 is_priv", out_is_priv, 1);
    check("t4 priv_id", out_id, 0);
    check("t4 priv_val", out_val, 64'd3);
    tick();
    check("t4 idle", out_valid, 0);

    // T5: a value that returns to its shadow while blocked emits nothing
    vals[3] = 64'hA;
    drain(10);
    check("t5 setup e3", seen_cnt[3], 1);
    out_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c % 2 == 0) vals[0] = 64'h7000 + 64'(c);
      else            vals[1] = 64'h7000 + 64'(c);
      tick();
    end
    check("t5 full", pending, 16);
    vals[3] = 64'hB;
    tick();
    tick();
    vals[3] = 64'hA;
    tick();
    check("t5 still_full", pending, 16);
    drain(40);
    check("t5 no_e3", seen_cnt[3], 0);
    check("t5 drained", n_drained, 16);
    check("t5 last e0", last_val[0], 64'h700E);
    check("t5 last e1", last_val[1], 64'h700F);

    // T6: resync re-emits everything in index order
    resync = 1'b1;
    tick();
    resync = 1'b0;
    for (int k = 0; k < 8; k++) expect_update($sformatf("t6 e%0d", k), 1'b0, ids[k], vals[k]);
    expect_update("t6 priv", 1'b1, 12'h0, 64'd3);
    tick();
    check("t6 idle", out_valid, 0);

    // Reset mid-stream clears the queue without waiting for a clock edge
    out_ready = 1'b0;
    resync = 1'b1;
    tick();
    resync = 1'b0;
    repeat (4) tick();
    check("rmid pending_before", pending, 4);
    check("rmid valid_before", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rmid out_valid", out_valid, 0);
    check("rmid pending", pending, 0);
    check("rmid out_id", out_id, 0);
    check("rmid out_val", out_val, 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    expect_update("rmid e0", 1'b0, ids[0], vals[0]);
    expect_update("rmid e1", 1'b0, ids[1], vals[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
